// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, paces InstructionMemory reads with wait states,
// and buffers fetched words in a 2-entry queue toward decode. FETCH_PERF_EN builds the perf counters.
module imem_fetch_ctrl #(
   parameter int unsigned WAIT_STATES = 2,
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR  = 32'hF000_0000
) (
   input  logic        CLK,
   input  logic        Reset_L,
   output logic [31:0] ImemAddress,
   input  logic [31:0] ImemData,
   output logic [31:0] InstrOut,
   output logic [31:0] InstrPC,
   output logic        InstrValid,
   input  logic        InstrReady,
   input  logic        Redirect,
   input  logic [31:0] RedirectPC,
   input  logic        Exception,
   output logic [31:0] FetchCount,
   output logic [31:0] StallCount
);

   typedef enum logic [1:0] {
      RST  = 2'd0,
      READ = 2'd1,
      FULL = 2'd2
   } state_t;

   localparam logic [3:0] LAST_WAIT = 4'(WAIT_STATES - 1);

   state_t      state, state_n;
   logic [3:0]  wait_cnt, wait_n;
   logic [31:0] pc, pc_n;
   logic        head_valid, hv_n;
   logic [31:0] head_data, hd_n;
   logic [31:0] head_pc, hp_n;
   logic        tail_valid, tv_n;
   logic [31:0] tail_data, td_n;
   logic [31:0] tail_pc, tp_n;
   logic        pop;
   logic        flush;
   logic        push;

   assign pop   = head_valid & InstrReady;
   assign flush = Exception | Redirect;

   assign ImemAddress = pc;
   assign InstrOut    = head_data;
   assign InstrPC     = head_pc;
   assign InstrValid  = head_valid;

   // RST behaves as the first wait cycle of a read, so the reset address gets its full wait
   always_comb begin
      state_n = state;
      wait_n  = wait_cnt;
      pc_n    = pc;
      push    = 1'b0;
      hv_n    = head_valid;
      hd_n    = head_data;
      hp_n    = head_pc;
      tv_n    = tail_valid;
      td_n    = tail_data;
      tp_n    = tail_pc;

      if (pop) begin
         hv_n = tail_valid;
         hd_n = tail_data;
         hp_n = tail_pc;
         tv_n = 1'b0;
      end

      if (flush) begin
         hv_n    = 1'b0;
         tv_n    = 1'b0;
         pc_n    = Exception ? EXC_VECTOR : (RedirectPC & 32'hFFFF_FFFC);
         state_n = READ;
         wait_n  = 4'd0;
      end else begin
         case (state)
            RST, READ: begin
               state_n = READ;
               if (wait_cnt == LAST_WAIT) begin
                  wait_n = 4'd0;
                  if (!(hv_n && tv_n)) begin
                     push = 1'b1;
                     pc_n = pc + 32'd4;
                  end else begin
                     state_n = FULL;
                  end
               end else begin
                  wait_n = wait_cnt + 4'd1;
               end
            end
            FULL: begin
               if (pop) begin
                  state_n = READ;
                  wait_n  = 4'd0;
               end
            end
            default: begin
               state_n = READ;
               wait_n  = 4'd0;
            end
         endcase
      end

      if (push) begin
         if (!hv_n) begin
            hv_n = 1'b1;
            hd_n = ImemData;
            hp_n = pc;
         end else begin
            tv_n = 1'b1;
            td_n = ImemData;
            tp_n = pc;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!Reset_L) begin
         state      <= RST;
         wait_cnt   <= 4'd0;
         pc         <= RESET_PC;
         head_valid <= 1'b0;
         head_data  <= 32'd0;
         head_pc    <= 32'd0;
         tail_valid <= 1'b0;
         tail_data  <= 32'd0;
         tail_pc    <= 32'd0;
      end else begin
         state      <= state_n;
         wait_cnt   <= wait_n;
         pc         <= pc_n;
         head_valid <= hv_n;
         head_data  <= hd_n;
         head_pc    <= hp_n;
         tail_valid <= tv_n;
         tail_data  <= td_n;
         tail_pc    <= tp_n;
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt;
   logic [31:0] stall_cnt;

   always_ff @(posedge CLK) begin
      if (!Reset_L) begin
         fetch_cnt <= 32'd0;
         stall_cnt <= 32'd0;
      end else begin
         if (pop) begin
            fetch_cnt <= fetch_cnt + 32'd1;
         end
         if (state == FULL) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
      end
   end

   assign FetchCount = fetch_cnt;
   assign StallCount = stall_cnt;
`else
   assign FetchCount = 32'd0;
   assign StallCount = 32'd0;
`endif

endmodule
